stepper_move_ctrl: RTL and testbench
====================================

Name: stepper_move_ctrl

Overview:
- Sequences a single stepper-motor driver (STEP/DIR/ENABLE) for the forklift axes.
- Accepts a move command (step count, direction, step period) over a valid/ready handshake.
- Generates dir setup, step pulses with a fixed pulse width, and a one-cycle completion pulse.
- Replaces free-running divided clocks with counted, abortable moves driven by the host/Qsys side.

Parameters:
- CNT_W, 32: width of period and timing counters.
- STEP_W, 16: width of step count and steps_done.
- PULSE_W, 100: clk cycles step_out is high per step; must be >= 1.
- DIR_SETUP, 50: clk cycles dir_out is stable before the first step edge; must be >= 1.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset_reset, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: a command is presented.
- cmd_ready, output, 1: the block can accept a command.
- cmd_steps, input, STEP_W: number of steps in the move.
- cmd_dir, input, 1: direction (1 = forward).
- cmd_period, input, CNT_W: clk cycles between consecutive step_out rising edges.
- abort, input, 1: stop the move early.
- step_out, output, 1: STEP pin to the driver.
- dir_out, output, 1: DIR pin to the driver.
- enable_out, output, 1: driver enable.
- busy, output, 1: a move is in progress.
- done, output, 1: one-cycle pulse when a move ends.
- aborted, output, 1: the last move ended by abort; valid from done until the next accept.
- steps_done, output, STEP_W: pulses completed in the current or last move.

Behaviour:
- Reset:
  - Synchronous; all outputs are 0 at the first edge with reset_reset=1, and state is IDLE.
  - Reset has priority over everything, including mid-pulse; step_out drops at that edge, so a truncated pulse is acceptable.
- States: IDLE, SETUP, PULSE, GAP, DONE.
- Derived outputs:
  - cmd_ready = (state==IDLE).
  - busy = (state!=IDLE).
  - enable_out = state in {SETUP, PULSE, GAP}.
  - step_out = (state==PULSE).
  - done = (state==DONE).
- IDLE:
  - Accept when cmd_valid && cmd_ready; latch steps, dir and effective period; clear steps_done and aborted.
  - Effective period = max(cmd_period, 2*PULSE_W); shorter values are clamped, not rejected.
  - cmd_steps==0 goes to DONE, with no enable and no step. Otherwise go to SETUP and load dir_out=cmd_dir.
  - cmd_valid while not IDLE is ignored and not queued.
- SETUP: lasts exactly DIR_SETUP cycles, then PULSE.
- PULSE:
  - Lasts exactly PULSE_W cycles.
  - On exit, steps_done increments; the new value is visible in the next state's first cycle.
  - Exit to GAP normally. Exit to DONE if this was the last step or abort was seen during SETUP/PULSE.
- GAP:
  - Lasts exactly (period - PULSE_W) cycles, then PULSE.
  - Abort in GAP goes to DONE on the next edge.
- DONE: lasts 1 cycle, then IDLE; cmd_ready is high the following cycle.
- Abort:
  - Sampled only in SETUP/PULSE/GAP; ignored in IDLE/DONE, including the accept cycle.
  - Abort in SETUP goes to DONE on the next edge with no step.
  - Abort in PULSE latches a flag; the pulse completes at full width, then DONE.
  - aborted=1 is set on the transition to DONE.
- Timing (accept at edge 0, so state cycle 1 is the first non-IDLE cycle):
  - First step_out high: cycle 1+DIR_SETUP.
  - Step n rises at 1+DIR_SETUP+(n-1)*period.
  - done asserts at 1+DIR_SETUP+steps*period-(period-PULSE_W).
- dir_out holds its value through IDLE until the next accepted command.
- Counters:
  - Internal cycle counters are CNT_W bits, reloaded at each state entry.
  - No wrap within a move because period fits CNT_W.
  - steps_done never exceeds cmd_steps.

Test Plan (PULSE_W=4, DIR_SETUP=3):
1. steps=3, dir=1, period=10, accepted at edge 0:
   - dir_out=1 and enable_out=1 from cycle 1.
   - step_out high on cycles 4-7, 14-17 and 24-27.
   - done on cycle 28, steps_done=3, aborted=0, cmd_ready=1 on cycle 29.
2. steps=0, accepted at edge 0 -> done on cycle 1; step_out and enable_out stay 0; steps_done=0.
3. steps=2, period=5 -> clamped to 8; step_out high on 4-7 and 12-15; done on cycle 16.
4. Abort handling:
   - Test 1 move, abort pulsed on cycle 15 (mid second pulse): step_out stays high through 17, done on cycle 18, steps_done=2, aborted=1.
   - Repeat with abort on cycle 2: done on cycle 3, steps_done=0.
5. reset_reset high on cycle 5 during the first pulse -> from cycle 6 all outputs are 0 and cmd_ready=1; a new command is accepted normally.
6. cmd_valid held high with new data throughout test 1 -> not accepted until cycle 29; the second move uses the data presented at cycle 29, not the data presented while busy.

Source files
------------

// File: rtl/stepper_move_ctrl.sv
// rtl/stepper_move_ctrl.sv - counted, abortable STEP/DIR/ENABLE move sequencer
module stepper_move_ctrl #(
  parameter int CNT_W     = 32,
  parameter int STEP_W    = 16,
  parameter int PULSE_W   = 100,
  parameter int DIR_SETUP = 50
) (
  input  logic              clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              step_out,
  output logic              dir_out,
  output logic              enable_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2 * PULSE_W);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] PULSE_CYC  = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_q;
  logic [STEP_W-1:0] steps_q;
  logic              abort_pend;
  logic              last_step;

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign enable_out = (state == S_SETUP) || (state == S_PULSE) || (state == S_GAP);
  assign step_out   = (state == S_PULSE);
  assign done       = (state == S_DONE);
  assign last_step  = ((steps_done + STEP_W'(1)) == steps_q);

  // cnt counts down to zero; each state's duration is loaded on entry
  always_ff @(posedge clk) begin
    if (reset_reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      period_q   <= '0;
      steps_q    <= '0;
      abort_pend <= 1'b0;
      dir_out    <= 1'b0;
      aborted    <= 1'b0;
      steps_done <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            steps_q    <= cmd_steps;
            period_q   <= (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
            steps_done <= '0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            if (cmd_steps == '0) begin
              state <= S_DONE;
            end else begin
              state   <= S_SETUP;
              dir_out <= cmd_dir;
              cnt     <= SETUP_LOAD;
            end
          end
        end
        S_SETUP: begin
          if (abort) begin
            state   <= S_DONE;
            aborted <= 1'b1;
          end else if (cnt == '0) begin
            state <= S_PULSE;
            cnt   <= PULSE_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_PULSE: begin
          // an abort mid-pulse never truncates the pulse; it only ends the move after it
          if (cnt == '0) begin
            steps_done <= steps_done + STEP_W'(1);
            if (last_step || abort_pend || abort) begin
              state   <= S_DONE;
              aborted <= abort_pend | abort;
            end else begin
              state <= S_GAP;
              cnt   <= period_q - PULSE_CYC - CNT_ONE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
            if (abort) abort_pend <= 1'b1;
          end
        end
        S_GAP: begin
          if (abort) begin
            state   <= S_DONE;
            aborted <= 1'b1;
          end else if (cnt == '0) begin
            state <= S_PULSE;
            cnt   <= PULSE_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb/tb_stepper_move_ctrl.sv - scoreboard bench for stepper_move_ctrl
module tb_stepper_move_ctrl;

  localparam int CNT_W  = 32;
  localparam int STEP_W = 16;
  localparam int PW     = 4;
  localparam int DS     = 3;

  logic              clk = 1'b0;
  logic              reset_reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic [CNT_W-1:0]  cmd_period;
  logic              abort;
  logic              step_out;
  logic              dir_out;
  logic              enable_out;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_done;

  stepper_move_ctrl #(
    .CNT_W(CNT_W), .STEP_W(STEP_W), .PULSE_W(PW), .DIR_SETUP(DS)
  ) dut (
    .clk(clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
    .abort(abort), .step_out(step_out), .dir_out(dir_out),
    .enable_out(enable_out), .busy(busy), .done(done),
    .aborted(aborted), .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  // number of rising edges so far; a move accepted at edge A shows cycle n at edge_cnt == A+n-1
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int   t;
    int   sd;
    logic ab;
    logic dr;
  } done_t;

  int    step_q[$];
  done_t done_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  logic  prev_step = 1'b0;
  logic  prev_done = 1'b0;
  done_t e;
  always @(negedge clk) begin
    if (!reset_reset) begin
      if (step_out && !prev_step) begin
        if (step_q.size() == 0) chk("step_unexpected", edge_cnt, -1);
        else chk("step_rise_cycle", edge_cnt, step_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", edge_cnt, -1);
        end else begin
          e = done_q.pop_front();
          chk("done_cycle", edge_cnt, e.t);
          chk("done_steps_done", steps_done, e.sd);
          chk("done_aborted", aborted, e.ab);
          chk("done_dir_out", dir_out, e.dr);
        end
      end
      if (prev_done) chk("ready_after_done", cmd_ready, 1);
    end
    prev_step = step_out;
    prev_done = done;
  end

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("ready_timeout", cmd_ready, 1);
  endtask

  task automatic start_cmd(input int steps, input logic d, input int period, output int a);
    wait_ready();
    cmd_valid  = 1'b1;
    cmd_steps  = STEP_W'(steps);
    cmd_dir    = d;
    cmd_period = CNT_W'(period);
    a          = edge_cnt + 1;
  endtask

  task automatic push_move(input int a, input int steps, input int p, input logic d);
    done_t x;
    for (int n = 1; n <= steps; n++) step_q.push_back(a + DS + (n - 1) * p);
    x.t  = (steps == 0) ? a : a + DS + steps * p - p + PW;
    x.sd = steps;
    x.ab = 1'b0;
    x.dr = d;
    done_q.push_back(x);
  endtask

  task automatic push_done(input int t, input int sd, input logic ab, input logic d);
    done_t x;
    x.t  = t;
    x.sd = sd;
    x.ab = ab;
    x.dr = d;
    done_q.push_back(x);
  endtask

  task automatic wait_until(input int t);
    while (edge_cnt < t) @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while ((step_q.size() != 0 || done_q.size() != 0 || !cmd_ready) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", step_q.size() + done_q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_step_out"}, step_out, 0);
    chk({tag, "_dir_out"}, dir_out, 0);
    chk({tag, "_enable_out"}, enable_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_steps_done"}, steps_done, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int a2;
    reset_reset = 1'b1;
    cmd_valid   = 1'b0;
    cmd_steps   = '0;
    cmd_dir     = 1'b0;
    cmd_period  = '0;
    abort       = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    reset_reset = 1'b0;
    @(negedge clk);

    // 3 steps, period 10, with cmd_valid held high carrying junk while busy
    start_cmd(3, 1'b1, 10, a);
    push_move(a, 3, 10, 1'b1);
    @(negedge clk);
    chk("t1_c1_dir_out", dir_out, 1);
    chk("t1_c1_enable_out", enable_out, 1);
    chk("t1_c1_cmd_ready", cmd_ready, 0);
    while (edge_cnt < a + 28) begin
      cmd_steps  = STEP_W'(5 + edge_cnt % 3);
      cmd_dir    = 1'b0;
      cmd_period = CNT_W'(20);
      @(negedge clk);
    end
    chk("t1_c29_cmd_ready", cmd_ready, 1);
    chk("t1_c29_steps_done", steps_done, 3);
    cmd_steps  = STEP_W'(1);
    cmd_dir    = 1'b0;
    cmd_period = CNT_W'(8);
    a2 = edge_cnt + 1;
    push_move(a2, 1, 8, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // zero-step move: immediate done, no enable, dir untouched
    start_cmd(0, 1'b1, 10, a);
    push_move(a, 0, 10, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t2_c1_enable_out", enable_out, 0);
    chk("t2_c1_step_out", step_out, 0);
    drain();

    // period 5 clamps to 8
    start_cmd(2, 1'b1, 5, a);
    push_move(a, 2, 8, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // abort mid second pulse
    start_cmd(3, 1'b1, 10, a);
    step_q.push_back(a + 3);
    step_q.push_back(a + 13);
    push_done(a + 17, 2, 1'b1, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_until(a + 14);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();

    // abort during dir setup
    start_cmd(3, 1'b0, 10, a);
    push_done(a + 2, 0, 1'b1, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_until(a + 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();

    // aborted clears on the next accept
    start_cmd(1, 1'b1, 8, a);
    push_move(a, 1, 8, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("after_abort_c1_aborted", aborted, 0);
    drain();

    // reset during the first pulse
    start_cmd(3, 1'b1, 10, a);
    step_q.push_back(a + 3);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_until(a + 4);
    reset_reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midreset");
    reset_reset = 1'b0;
    chk("midreset_first_step_seen", step_q.size(), 0);
    step_q.delete();
    done_q.delete();
    start_cmd(2, 1'b0, 8, a);
    push_move(a, 2, 8, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
